// File: rtl/sens_uart_arbiter_pkg.sv
// Shared types and helpers for the UART transmitter round-robin arbiter.
package sens_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int ARB_MAX_REQ = 8;

  // Index width for n requesters: clog2(n), never less than one bit.
  function automatic int arb_idx_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << w) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sens_uart_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first eligible index at or after start, wrapping.
module sens_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk N positions from start; the earliest eligible one in rotation order wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, start} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end else begin
        sum = sum;
      end
      cand = sum[IW-1:0];
      if (eligible[cand] && !found) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sens_uart_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ motes.
// Optional hold watchdog enabled by defining SENS_ARB_TIMEOUT_EN.
module sens_uart_arbiter
  import sens_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_HOLD   = 5_000_000
) (
  input  logic                              clk50,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                bus_request,
  input  logic [NUM_REQ*DATA_W-1:0]         req_data,
  input  logic [NUM_REQ-1:0]                req_txd_start,
  input  logic                              txd_busy,
  output logic [NUM_REQ-1:0]                bus_grant,
  output logic                              txd_start,
  output logic [DATA_W-1:0]                 txd_data,
  output logic [arb_idx_w(NUM_REQ)-1:0]     grant_id,
  output logic                              timeout_pulse
);

  localparam int              IW        = arb_idx_w(NUM_REQ);
  localparam logic [31:0]     HOLD_LAST = 32'(MAX_HOLD - 1);
  localparam logic [31:0]     GAP_LOAD  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0]     HOLD_SAT  = 32'hFFFF_FFFF;
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_REQ - 1);

`ifdef SENS_ARB_TIMEOUT_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif

  arb_state_t           state;
  logic [IW-1:0]        last_owner;
  logic [31:0]          hold_cnt;
  logic [31:0]          gap_cnt;
  logic [NUM_REQ-1:0]   lockout;
  logic [NUM_REQ-1:0]   lockout_keep;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IW-1:0]        start_idx;
  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic                 owner_req;
  logic                 hold_hit;
  logic [DATA_W-1:0]    sel_data;
  logic [DATA_W-1:0]    data_hold;

  // Locked-out motes stay ineligible until they drop their request once.
  assign lockout_keep = WDOG_EN ? (lockout & bus_request) : '0;
  assign eligible     = bus_request & ~lockout;
  assign start_idx    = (last_owner == LAST_IDX) ? '0 : last_owner + IW'(1);
  assign pick_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign owner_req    = |(bus_request & bus_grant);
  assign hold_hit     = WDOG_EN && (hold_cnt == HOLD_LAST);

  sens_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .eligible (eligible),
    .start    (start_idx),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // One-hot AND-OR mux of the owner's byte; zero when nobody holds the bus.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_data = sel_data | (req_data[i*DATA_W +: DATA_W] & {DATA_W{bus_grant[i]}});
    end
  end

  assign txd_start = |(req_txd_start & bus_grant);
  assign txd_data  = (|bus_grant) ? sel_data : data_hold;

  // Arbitration FSM: grant, release, drain transmitter, then idle guard gap.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state         <= IDLE;
      bus_grant     <= '0;
      grant_id      <= '0;
      last_owner    <= LAST_IDX;
      hold_cnt      <= 32'd0;
      gap_cnt       <= 32'd0;
      lockout       <= '0;
      timeout_pulse <= 1'b0;
      data_hold     <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      lockout       <= lockout_keep;
      if (|bus_grant) begin
        data_hold <= sel_data;
      end
      case (state)
        IDLE: begin
          if (pick_found) begin
            bus_grant  <= pick_onehot;
            grant_id   <= pick_idx;
            last_owner <= pick_idx;
            hold_cnt   <= 32'd0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 32'd1;
          end
          if (!owner_req) begin
            bus_grant <= '0;
            state     <= DRAIN;
          end else if (hold_hit) begin
            bus_grant     <= '0;
            timeout_pulse <= 1'b1;
            lockout       <= lockout_keep | bus_grant;
            state         <= DRAIN;
          end
        end
        DRAIN: begin
          if (!txd_busy) begin
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 32'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        default: begin
          bus_grant <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sens_uart_arbiter.sv
// Self-checking bench for sens_uart_arbiter (NUM_REQ=2, GAP_CYCLES=4, MAX_HOLD=100).
module tb_sens_uart_arbiter;

  logic        clk50 = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] rdata;
  logic [1:0]  rstart;
  logic        busy;
  logic [1:0]  bus_grant;
  logic        txd_start;
  logic [7:0]  txd_data;
  logic [0:0]  grant_id;
  logic        timeout_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk50 = ~clk50;

  sens_uart_arbiter #(
    .NUM_REQ    (2),
    .DATA_W     (8),
    .GAP_CYCLES (4),
    .MAX_HOLD   (100)
  ) dut (
    .clk50         (clk50),
    .reset         (reset),
    .bus_request   (req),
    .req_data      (rdata),
    .req_txd_start (rstart),
    .txd_busy      (busy),
    .bus_grant     (bus_grant),
    .txd_start     (txd_start),
    .txd_data      (txd_data),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [15:0] data;
    logic [1:0]  st;
    logic        busy;
    logic [1:0]  e_grant;
    logic        e_start;
    logic [7:0]  e_data;
    logic        e_id;
  } vec_t;

  vec_t vecs [22];

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = 2'b00;
    rstart = 2'b00;
    busy   = 1'b0;
    rdata  = 16'h335A;
    tick();
    reset  = 1'b0;
  endtask

  initial begin
    int n;
    int hits;
    int code;

    reset  = 1'b1;
    req    = 2'b00;
    rdata  = 16'h0000;
    rstart = 2'b00;
    busy   = 1'b0;

    //           rst   req    data      st     busy  grant  start data   id
    vecs[0]  = '{1'b1, 2'b00, 16'h335A, 2'b00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 16'h335A, 2'b00, 1'b0, 2'b01, 1'b0, 8'h5A, 1'b0};
    vecs[2]  = '{1'b0, 2'b01, 16'h335A, 2'b01, 1'b0, 2'b01, 1'b1, 8'h5A, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 16'h33A5, 2'b10, 1'b0, 2'b01, 1'b0, 8'hA5, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 16'h33A5, 2'b00, 1'b1, 2'b00, 1'b0, 8'hA5, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 16'h3311, 2'b01, 1'b1, 2'b00, 1'b0, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 16'h3311, 2'b00, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0};
    vecs[7]  = '{1'b0, 2'b10, 16'h3311, 2'b00, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 2'b10, 16'h3311, 2'b00, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 16'h3311, 2'b00, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 16'h3311, 2'b00, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0};
    vecs[11] = '{1'b0, 2'b10, 16'h3311, 2'b00, 1'b0, 2'b10, 1'b0, 8'h33, 1'b1};
    vecs[12] = '{1'b0, 2'b11, 16'h3311, 2'b11, 1'b0, 2'b10, 1'b1, 8'h33, 1'b1};
    vecs[13] = '{1'b0, 2'b01, 16'h4411, 2'b00, 1'b0, 2'b00, 1'b0, 8'h44, 1'b1};
    vecs[14] = '{1'b0, 2'b01, 16'h4411, 2'b00, 1'b0, 2'b00, 1'b0, 8'h44, 1'b1};
    vecs[15] = '{1'b0, 2'b01, 16'h4411, 2'b00, 1'b0, 2'b00, 1'b0, 8'h44, 1'b1};
    vecs[16] = '{1'b0, 2'b01, 16'h4411, 2'b00, 1'b0, 2'b00, 1'b0, 8'h44, 1'b1};
    vecs[17] = '{1'b0, 2'b01, 16'h4411, 2'b00, 1'b0, 2'b00, 1'b0, 8'h44, 1'b1};
    vecs[18] = '{1'b0, 2'b01, 16'h4411, 2'b00, 1'b0, 2'b00, 1'b0, 8'h44, 1'b1};
    vecs[19] = '{1'b0, 2'b01, 16'h4411, 2'b00, 1'b0, 2'b01, 1'b0, 8'h11, 1'b0};
    vecs[20] = '{1'b1, 2'b01, 16'h4411, 2'b01, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0};
    vecs[21] = '{1'b0, 2'b11, 16'h4411, 2'b00, 1'b0, 2'b01, 1'b0, 8'h11, 1'b0};

    #2;
    for (int i = 0; i < 22; i++) begin
      reset  = vecs[i].rst;
      req    = vecs[i].req;
      rdata  = vecs[i].data;
      rstart = vecs[i].st;
      busy   = vecs[i].busy;
      tick();
      check($sformatf("v%0d grant", i), 32'(bus_grant), 32'(vecs[i].e_grant));
      check($sformatf("v%0d start", i), 32'(txd_start), 32'(vecs[i].e_start));
      check($sformatf("v%0d data", i),  32'(txd_data),  32'(vecs[i].e_data));
      check($sformatf("v%0d id", i),    32'(grant_id),  32'(vecs[i].e_id));
      check($sformatf("v%0d tmo", i),   32'(timeout_pulse), 32'd0);
    end

    // Drain with transmitter busy for 10 cycles from the drop edge.
    do_reset();
    req = 2'b11;
    tick();
    check("drain first owner", 32'(bus_grant), 32'd1);
    req    = 2'b10;
    busy   = 1'b1;
    rstart = 2'b11;
    tick();
    check("drain grant drop", 32'(bus_grant), 32'd0);
    n    = 0;
    hits = 0;
    code = 0;
    while (code == 0 && n < 40) begin
      n++;
      if (n == 10) busy = 1'b0;
      tick();
      if (bus_grant == 2'b10) begin
        code = n;
      end else if (txd_start != 1'b0) begin
        hits++;
      end
    end
    check("drain regrant delay", 32'(code), 32'd15);
    check("drain start quiet", 32'(hits), 32'd0);

    // Continuous requests with a one-cycle drop after each frame alternate owners.
    do_reset();
    req = 2'b11;
    for (int t = 0; t < 8; t++) begin
      n = 0;
      while (bus_grant == 2'b00 && n < 20) begin
        tick();
        n++;
      end
      code = (bus_grant == 2'b01) ? 0 : (bus_grant == 2'b10) ? 1 : 15;
      check($sformatf("alt%0d owner", t), 32'(code), 32'(t % 2));
      repeat (3) tick();
      req = 2'b11 & ~bus_grant;
      tick();
      req = 2'b11;
    end

`ifdef SENS_ARB_TIMEOUT_EN
    // Watchdog revokes a stuck owner and locks it out until its request drops.
    do_reset();
    req = 2'b11;
    tick();
    check("wd first grant", 32'(bus_grant), 32'd1);
    n = 0;
    while (bus_grant == 2'b01 && n < 200) begin
      tick();
      n++;
    end
    check("wd revoke cycle", 32'(n), 32'd100);
    check("wd pulse high", 32'(timeout_pulse), 32'd1);
    tick();
    check("wd pulse low", 32'(timeout_pulse), 32'd0);
    n = 0;
    while (bus_grant == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("wd next owner", 32'(bus_grant), 32'd2);
    req  = 2'b01;
    hits = 0;
    repeat (20) begin
      tick();
      if (bus_grant != 2'b00) hits++;
    end
    check("wd lockout holds", 32'(hits), 32'd0);
    req = 2'b00;
    tick();
    req = 2'b01;
    n = 0;
    while (bus_grant == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    check("wd lockout cleared", 32'(bus_grant), 32'd1);
`else
    // Without the watchdog a grant is held indefinitely.
    do_reset();
    req = 2'b01;
    tick();
    check("hold first grant", 32'(bus_grant), 32'd1);
    hits = 0;
    n    = 0;
    repeat (150) begin
      tick();
      if (bus_grant != 2'b01) hits++;
      if (timeout_pulse != 1'b0) n++;
    end
    check("hold no revoke", 32'(hits), 32'd0);
    check("hold no pulse", 32'(n), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sens_uart_arbiter.md
# sens_uart_arbiter

Round-robin arbiter that shares the single PC-bound `async_transmitter` (115200 baud) between `NUM_REQ` motes. It replaces fixed-priority request/grant logic with registered grants, fair rotation and a drain/guard sequence so a mote's frame is never cut mid-byte. An optional hold watchdog stops a stuck mote from starving the others. It sits between the motes' `bus_request`/`mote_out`/`txd_start` outputs and the transmitter's `TxD_start`/`TxD_data`/`TxD_busy`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..8).
- `DATA_W`, 8: byte width forwarded to the transmitter.
- `GAP_CYCLES`, 4: idle guard cycles between grants (≥1).
- `MAX_HOLD`, 5_000_000: max grant duration in clk50 cycles (watchdog only).

Ports:
- `clk50` in 1: 50 MHz clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `bus_request` in NUM_REQ: level request per mote; held high for the whole transaction.
- `req_data` in NUM_REQ*DATA_W: per-mote byte; slice i is at [i*DATA_W +: DATA_W].
- `req_txd_start` in NUM_REQ: per-mote start pulse.
- `txd_busy` in 1: transmitter busy.
- `bus_grant` out NUM_REQ: one-hot or zero registered grant.
- `txd_start` out 1: muxed start to the transmitter.
- `txd_data` out DATA_W: muxed byte.
- `grant_id` out clog2(NUM_REQ) (min 1): index of the current or last owner.
- `timeout_pulse` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- FSM states: IDLE, GRANT, DRAIN, GAP.
- **IDLE**
  - Masks requests with `lockout`.
  - Picks the first eligible index, searching cyclically from `last_owner+1`.
  - If one is found: registers the one-hot `bus_grant`, updates `grant_id`/`last_owner`, clears `hold_cnt`, goes to GRANT.
- **GRANT**
  - `txd_start = req_txd_start[grant_id]`; `txd_data` is the owner's slice.
  - Owner's request falls: go to DRAIN and drop `bus_grant` on the same edge.
- **DRAIN**
  - `txd_start` forced to 0; `txd_data` holds the last owner value.
  - Waits for `txd_busy==0`, then loads `gap_cnt=GAP_CYCLES-1` and goes to GAP.
- **GAP**
  - Counts down to 0, then returns to IDLE. No grants are issued in GAP.
- Outside GRANT: `txd_start=0` and `bus_grant=0`.
- Requests from non-owners are ignored until IDLE. Simultaneous requests are resolved only by the rotation order.
- `hold_cnt` is a saturating 32-bit counter. It increments every GRANT cycle.

## Timing
- Reset values: `bus_grant=0`, `txd_start=0`, `txd_data=0`, `grant_id=0`, `timeout_pulse=0`, `last_owner=NUM_REQ-1` (so index 0 wins first), `lockout=0`, state IDLE.
- Reset mid-transaction behaves the same as power-up. A transmitter byte already in flight is not aborted.
- Grant latency: request high at edge k in IDLE → `bus_grant` high after edge k+1.
- `txd_start` and `txd_data` are combinational from registered `bus_grant` and the requester inputs: zero added latency in GRANT.
- Release sequence:
  - Request low at edge k → grant low after edge k.
  - DRAIN lasts ≥1 cycle, plus however long `txd_busy` stays high.
  - GAP lasts GAP_CYCLES.
  - Earliest new grant is at k+GAP_CYCLES+2 (DRAIN one cycle, then GAP_CYCLES, then the IDLE decision cycle).
- Single requester: re-granted after the guard sequence; there is no fairness penalty.

## Configuration
- `SENS_ARB_TIMEOUT_EN` defined:
  - In GRANT, when `hold_cnt` reaches MAX_HOLD-1: go to DRAIN, pulse `timeout_pulse` for 1 cycle, set `lockout[grant_id]`.
  - A `lockout` bit clears on any cycle where that mote's `bus_request` is low.
- Undefined: no watchdog. `timeout_pulse` is tied to 0, the `lockout` logic is absent and grants are unbounded.

## Structure
- Package `sens_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, GRANT, DRAIN, GAP);
  - constant `ARB_MAX_REQ=8`;
  - function `arb_idx_w(n)` (clog2 with minimum 1).
- Sub-module `sens_rr_pick`: combinational rotating priority encoder. Inputs: eligible mask and start index. Outputs: `found` and index.

## Test plan
- Reset then `bus_request=2'b01` → `bus_grant=01` one cycle later; `txd_data` tracks `req_data[7:0]=0x5A`.
- Both request from reset → mote 0 granted first. Mote 0 drops while `txd_busy` is high for 10 cycles → mote 1 granted exactly 10+GAP_CYCLES+1 cycles after the drop; `txd_start` is 0 throughout.
- Both requesters hold requests continuously (drop for 1 cycle after each frame) → grants alternate 0,1,0,1 over 8 transactions.
- `req_txd_start[1]` pulsed while mote 0 owns the bus → `txd_start` stays 0.
- With SENS_ARB_TIMEOUT_EN and MAX_HOLD=100, mote 0 holds its request → grant revoked at cycle 100, `timeout_pulse` high 1 cycle, mote 1 granted next; mote 0 stays ineligible until its request goes low.
- Reset asserted mid-GRANT → all outputs 0 on the next edge; first post-reset grant goes to mote 0.
